// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter: DMCtrl encodings,
// the registered command record and the access legality rule.
package dmem_pkg;

    localparam logic [2:0] DMCTRL_B  = 3'b000;
    localparam logic [2:0] DMCTRL_H  = 3'b001;
    localparam logic [2:0] DMCTRL_W  = 3'b010;
    localparam logic [2:0] DMCTRL_BU = 3'b100;
    localparam logic [2:0] DMCTRL_HU = 3'b101;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ctrl;
        owner_e      owner;
        logic        err;
    } dmem_cmd_t;

    // Legal = known ctrl code, natural alignment for its size, and inside the array.
    function automatic logic dmem_legal(input logic [2:0] ctrl, input logic [31:0] addr,
                                        input int unsigned depth);
        logic [33:0] limit;
        logic        ok;
        limit = {depth, 2'b00};
        case (ctrl)
            DMCTRL_B, DMCTRL_BU: ok = 1'b1;
            DMCTRL_H, DMCTRL_HU: ok = ~addr[0];
            DMCTRL_W:            ok = (addr[1:0] == 2'b00);
            default:             ok = 1'b0;
        endcase
        return ok && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's req/gnt command channel plus its registered response.
interface dmem_arbiter_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, wr, addr, wdata, ctrl,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, wr, addr, wdata, ctrl,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_access_check.sv
// Combinational legality check applied to the command that wins arbitration.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic [2:0]  ctrl,
    input  logic [31:0] addr,
    output logic        err
);

    assign err = ~dmem_legal(ctrl, addr, DEPTH_WORDS);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: accept, issue, respond
// (latency 2, one accept per cycle), with anti-starvation priority for B.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned MAX_WAIT    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        a,
    dmem_arbiter_if.slave        b,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic                 mem_wr,
    output logic [2:0]           mem_ctrl,
    input  logic [31:0]          mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic [WCW-1:0] r_wait_cnt;
    logic           w_wait_full;
    logic           w_a_gnt;
    logic           w_b_gnt;
    logic           w_accept;
    logic           w_chk_err;
    dmem_cmd_t      w_sel;
    dmem_cmd_t      w_cmd;

    logic           r_issue_vld;
    dmem_cmd_t      r_issue;
    logic           w_issue_a;
    logic           w_issue_b;
    logic [31:0]    w_rsp_rdata;

    logic           r_a_rvalid;
    logic [31:0]    r_a_rdata;
    logic           r_a_err;
    logic           r_b_rvalid;
    logic [31:0]    r_b_rdata;
    logic           r_b_err;

    assign w_wait_full = (r_wait_cnt == WCW'(MAX_WAIT));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (rst_n) begin
            if (b.req && (!a.req || w_wait_full)) begin
                w_b_gnt = 1'b1;
            end else if (a.req) begin
                w_a_gnt = 1'b1;
            end
        end
    end

    assign a.gnt    = w_a_gnt;
    assign b.gnt    = w_b_gnt;
    assign w_accept = w_a_gnt | w_b_gnt;

    always_comb begin
        w_sel = '0;
        if (w_b_gnt) begin
            w_sel.wr    = b.wr;
            w_sel.addr  = b.addr;
            w_sel.wdata = b.wdata;
            w_sel.ctrl  = b.ctrl;
            w_sel.owner = OWNER_B;
        end else begin
            w_sel.wr    = a.wr;
            w_sel.addr  = a.addr;
            w_sel.wdata = a.wdata;
            w_sel.ctrl  = a.ctrl;
            w_sel.owner = OWNER_A;
        end
    end

    dmem_access_check #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_check (
        .ctrl (w_sel.ctrl),
        .addr (w_sel.addr),
        .err  (w_chk_err)
    );

    always_comb begin
        w_cmd     = w_sel;
        w_cmd.err = w_chk_err;
    end

    // NOTE: state registers use non-blocking assignments and clear asynchronously on rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!b.req || w_b_gnt) begin
            r_wait_cnt <= '0;
        end else if (!w_wait_full) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
        end
    end

    // Address/data only load on accept so they hold their last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_vld <= 1'b0;
            r_issue     <= '0;
        end else begin
            r_issue_vld <= w_accept;
            if (w_accept) begin
                r_issue <= w_cmd;
            end
        end
    end

    assign mem_addr  = r_issue.addr;
    assign mem_wdata = r_issue.wdata;
    assign mem_wr    = r_issue_vld & r_issue.wr & ~r_issue.err;
    assign mem_ctrl  = (r_issue_vld && !r_issue.err) ? r_issue.ctrl : DMCTRL_W;

    assign w_issue_a   = r_issue_vld && (r_issue.owner == OWNER_A);
    assign w_issue_b   = r_issue_vld && (r_issue.owner == OWNER_B);
    assign w_rsp_rdata = (r_issue_vld && !r_issue.wr && !r_issue.err) ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_a_err    <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= '0;
            r_b_err    <= 1'b0;
        end else begin
            r_a_rvalid <= w_issue_a;
            r_a_rdata  <= w_issue_a ? w_rsp_rdata : 32'h0;
            r_a_err    <= w_issue_a & r_issue.err;
            r_b_rvalid <= w_issue_b;
            r_b_rdata  <= w_issue_b ? w_rsp_rdata : 32'h0;
            r_b_err    <= w_issue_b & r_issue.err;
        end
    end

    assign a.rvalid = r_a_rvalid;
    assign a.rdata  = r_a_rdata;
    assign a.err    = r_a_err;
    assign b.rvalid = r_b_rvalid;
    assign b.rdata  = r_b_rdata;
    assign b.err    = r_b_err;

endmodule
